// File: rtl/reg_file_pkg.sv
// Shared widths, indices and word types for the ARM register file storage stage.
package reg_file_pkg;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;
    localparam int SEL_W    = 4;
    localparam int PC_IDX   = 15;

    typedef logic [DATA_W-1:0] reg_word_t;
    typedef logic [SEL_W-1:0]  reg_sel_t;

    localparam reg_word_t PC_STEP = 32'd4;
endpackage

// File: rtl/reg_decoder.sv
// 4-to-16 one-hot write-enable decoder; all outputs low when en is low.
module reg_decoder
    import reg_file_pkg::*;
(
    input  logic                en,
    input  reg_sel_t            sel,
    output logic [NUM_REGS-1:0] onehot
);

    // Decode the select into a single enable bit, gated by en
    always_comb begin
        onehot = {NUM_REGS{1'b0}};
        if (en) begin
            onehot[sel] = 1'b1;
        end else begin
            onehot = {NUM_REGS{1'b0}};
        end
    end

endmodule

// File: rtl/register_bank.sv
// Storage for R0..R15 with one write port and dedicated PC (R15) load/increment logic.
// Optional write-through forwarding onto q_flat/pc_out is enabled by defining REG_WRITE_BYPASS_EN.
module register_bank
    import reg_file_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ld,
    input  logic [SEL_W-1:0]           rw_sel,
    input  logic [DATA_W-1:0]          pw,
    input  logic                       pc_ld,
    input  logic [DATA_W-1:0]          pc_in,
    input  logic                       pc_inc,
    output logic [NUM_REGS*DATA_W-1:0] q_flat,
    output logic [DATA_W-1:0]          pc_out
);

    logic [NUM_REGS-1:0]        we_s;
    logic [NUM_REGS*DATA_W-1:0] reg_q_s;
    reg_word_t                  pc_r;
    reg_word_t                  pc_next_s;

    reg_decoder u_dec (
        .en     (ld),
        .sel    (rw_sel),
        .onehot (we_s)
    );

    for (genvar n = 0; n < PC_IDX; n++) begin : g_gpr
        reg_word_t gpr_r;

        // General-purpose register n: cleared by rst, loaded when its enable is set
        always_ff @(posedge clk) begin
            if (rst) begin
                gpr_r <= {DATA_W{1'b0}};
            end else if (we_s[n]) begin
                gpr_r <= pw;
            end else begin
                gpr_r <= gpr_r;
            end
        end

        assign reg_q_s[n*DATA_W +: DATA_W] = gpr_r;
    end

    // R15 next state: branch load beats general write, which beats increment
    always_comb begin
        pc_next_s = pc_r;
        if (pc_ld) begin
            pc_next_s = pc_in;
        end else if (we_s[PC_IDX]) begin
            pc_next_s = pw;
        end else if (pc_inc) begin
            pc_next_s = pc_r + PC_STEP;
        end else begin
            pc_next_s = pc_r;
        end
    end

    // R15 register
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= {DATA_W{1'b0}};
        end else begin
            pc_r <= pc_next_s;
        end
    end

    assign reg_q_s[PC_IDX*DATA_W +: DATA_W] = pc_r;

`ifdef REG_WRITE_BYPASS_EN
    logic [NUM_REGS*DATA_W-1:0] fwd_q_s;

    // Forward the pending write onto the read bus; pc_ld overrides ld for R15
    always_comb begin
        fwd_q_s = reg_q_s;
        if (!rst) begin
            if (ld) begin
                fwd_q_s[int'(rw_sel)*DATA_W +: DATA_W] = pw;
            end else begin
                fwd_q_s = reg_q_s;
            end
            if (pc_ld) begin
                fwd_q_s[PC_IDX*DATA_W +: DATA_W] = pc_in;
            end else begin
                fwd_q_s[PC_IDX*DATA_W +: DATA_W] = fwd_q_s[PC_IDX*DATA_W +: DATA_W];
            end
        end else begin
            fwd_q_s = reg_q_s;
        end
    end

    assign q_flat = fwd_q_s;
    assign pc_out = fwd_q_s[PC_IDX*DATA_W +: DATA_W];
`else
    assign q_flat = reg_q_s;
    assign pc_out = pc_r;
`endif

endmodule
